axis_packet_splitter: RTL and testbench

Splits one incoming AXI-Stream packet into consecutive output packets, one per enabled output channel, each carrying a programmed number of words. Channels are served in ascending index order. This is the inverse of the packet joiner: it fans a single concatenated stream back out to per-channel consumers. It uses the same operation_start / busy / complete / error control handshake as the joiner.

---
 rtl/axis_packet_splitter_pkg.sv | 27 ++
 rtl/lsb_priority_encoder.sv | 32 +++
 rtl/axis_packet_splitter.sv | 206 ++++++++++++++++++++
 tb/tb_axis_packet_splitter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_packet_splitter_pkg.sv
// Shared definitions for the AXI-Stream packet splitter: width helper and FSM encoding.
`ifndef AXIS_PACKET_SPLITTER_LOG2
`define AXIS_PACKET_SPLITTER_LOG2
`define LOG2(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package axis_packet_splitter_pkg;

`ifdef USE_ONE_HOT_ENCODING_FSM
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_OPE   = 5'b00010,
    ST_DRAIN = 5'b00100,
    ST_ERR   = 5'b01000,
    ST_END   = 5'b10000
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPE   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_ERR   = 3'd3,
    ST_END   = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/lsb_priority_encoder.sv
// Picks the lowest set request bit; returns it one-hot and binary-encoded.
module lsb_priority_encoder
  import axis_packet_splitter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int OUT_W = `LOG2(WIDTH)
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] sel_o,
  output logic [OUT_W-1:0] sel_enc_o,
  output logic             valid_o
);

  logic found;

  always_comb begin
    sel_o     = '0;
    sel_enc_o = '0;
    found     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req_i[i] && !found) begin
        sel_o[i]  = 1'b1;
        sel_enc_o = i[OUT_W-1:0];
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
    valid_o = |req_i;
  end

endmodule

// File: rtl/axis_packet_splitter.sv
// Fans one AXI-Stream packet out into per-channel packets of programmed length,
// serving enabled channels in ascending order with a start/busy/complete/error handshake.
module axis_packet_splitter
  import axis_packet_splitter_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = ID_ENABLE ? 8 : 1,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = DEST_ENABLE ? 8 : 1,
  parameter int USER_ENABLE = 0,
  parameter int USER_WIDTH  = USER_ENABLE ? 8 : 1,
  parameter int LEN_WIDTH   = 16,
  parameter int ALLOW_LOCKS = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           operation_start,
  input  logic [CHANNELS-1:0]            use_channels,
  input  logic [CHANNELS*LEN_WIDTH-1:0]  split_lengths,
  input  logic                           lock,
  input  logic                           interrupt,
  output logic                           operation_busy,
  output logic                           operation_complete,
  output logic                           operation_error,
  output logic                           transmission,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [ID_WIDTH-1:0]            s_axis_tid,
  input  logic [DEST_WIDTH-1:0]          s_axis_tdest,
  input  logic [USER_WIDTH-1:0]          s_axis_tuser,
  output logic [CHANNELS*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [CHANNELS*KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [CHANNELS-1:0]            m_axis_tvalid,
  input  logic [CHANNELS-1:0]            m_axis_tready,
  output logic [CHANNELS-1:0]            m_axis_tlast,
  output logic [CHANNELS*ID_WIDTH-1:0]   m_axis_tid,
  output logic [CHANNELS*DEST_WIDTH-1:0] m_axis_tdest,
  output logic [CHANNELS*USER_WIDTH-1:0] m_axis_tuser
);

  localparam int SEL_W = `LOG2(CHANNELS);

  state_t                       state_q, state_d;
  logic [CHANNELS-1:0]          remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0]         cnt_q, cnt_d;
  logic [CHANNELS*LEN_WIDTH-1:0] len_q, len_d;
  logic                         busy_q, complete_q, error_q, trans_q;

  logic [CHANNELS-1:0] sel_oh;
  logic [SEL_W-1:0]    sel_idx;
  logic                sel_valid;
  logic [LEN_WIDTH-1:0] cur_len;
  logic                chan_last;
  logic                lock_act;
  logic                hs;
  logic                cfg_ok;

  lsb_priority_encoder #(
    .WIDTH (CHANNELS),
    .OUT_W (SEL_W)
  ) u_sel (
    .req_i     (remaining_q),
    .sel_o     (sel_oh),
    .sel_enc_o (sel_idx),
    .valid_o   (sel_valid)
  );

  assign cur_len   = len_q[sel_idx*LEN_WIDTH +: LEN_WIDTH];
  assign chan_last = (cnt_q == (cur_len - LEN_WIDTH'(1)));
  assign lock_act  = (ALLOW_LOCKS != 0) && lock;
  assign hs        = s_axis_tvalid && s_axis_tready;

  // Payload and sideband are broadcast; only tvalid/tlast are steered.
  assign m_axis_tdata = {CHANNELS{s_axis_tdata}};
  assign m_axis_tkeep = (KEEP_ENABLE != 0) ? {CHANNELS{s_axis_tkeep}} : {(CHANNELS*KEEP_WIDTH){1'b1}};
  assign m_axis_tid   = (ID_ENABLE != 0)   ? {CHANNELS{s_axis_tid}}   : '0;
  assign m_axis_tdest = (DEST_ENABLE != 0) ? {CHANNELS{s_axis_tdest}} : '0;
  assign m_axis_tuser = (USER_ENABLE != 0) ? {CHANNELS{s_axis_tuser}} : '0;

  assign operation_busy     = busy_q;
  assign operation_complete = complete_q;
  assign operation_error    = error_q;
  assign transmission       = trans_q;

  always_comb begin
    cfg_ok = |use_channels;
    for (int i = 0; i < CHANNELS; i++) begin
      if (use_channels[i] && (split_lengths[i*LEN_WIDTH +: LEN_WIDTH] == '0)) begin
        cfg_ok = 1'b0;
      end else begin
        cfg_ok = cfg_ok;
      end
    end
  end

  always_comb begin
    m_axis_tvalid = '0;
    m_axis_tlast  = '0;
    s_axis_tready = 1'b0;
    if (!lock_act) begin
      case (state_q)
        ST_OPE: begin
          if (sel_valid) begin
            m_axis_tvalid = sel_oh & {CHANNELS{s_axis_tvalid}};
            m_axis_tlast  = sel_oh & {CHANNELS{chan_last | s_axis_tlast}};
            s_axis_tready = |(sel_oh & m_axis_tready);
          end else begin
            s_axis_tready = 1'b0;
          end
        end
        ST_DRAIN: s_axis_tready = 1'b1;
        default:  s_axis_tready = 1'b0;
      endcase
    end else begin
      s_axis_tready = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    if (interrupt) begin
      state_d     = ST_IDLE;
      remaining_d = '0;
      cnt_d       = '0;
    end else if (lock_act) begin
      state_d = state_q;
    end else begin
      case (state_q)
        ST_IDLE, ST_END: begin
          if (operation_start) begin
            if (cfg_ok) begin
              state_d     = ST_OPE;
              remaining_d = use_channels;
              len_d       = split_lengths;
              cnt_d       = '0;
            end else begin
              state_d = ST_ERR;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_OPE: begin
          if (hs) begin
            if (chan_last) begin
              remaining_d = remaining_q & ~sel_oh;
              cnt_d       = '0;
              if (remaining_d == '0) begin
                state_d = s_axis_tlast ? ST_END : ST_DRAIN;
              end else begin
                state_d = s_axis_tlast ? ST_ERR : ST_OPE;
              end
            end else begin
              cnt_d   = cnt_q + LEN_WIDTH'(1);
              state_d = s_axis_tlast ? ST_ERR : ST_OPE;
            end
          end else begin
            state_d = ST_OPE;
          end
        end
        ST_DRAIN: begin
          if (hs && s_axis_tlast) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_ERR:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      cnt_q       <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      complete_q  <= 1'b0;
      error_q     <= 1'b0;
      trans_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      busy_q      <= (state_d == ST_OPE) || (state_d == ST_DRAIN);
      complete_q  <= (state_q == ST_OPE) && (state_d == ST_END);
      error_q     <= (state_d == ST_ERR);
      trans_q     <= hs;
    end
  end

endmodule

// File: tb/tb_axis_packet_splitter.sv
// Randomized self-checking bench: a word-list reference model predicts per-channel packets.
module tb_axis_packet_splitter;

  localparam int CH = 3;
  localparam int DW = 16;
  localparam int KW = 2;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          operation_start;
  logic [CH-1:0] use_channels;
  logic [CH*LW-1:0] split_lengths;
  logic          lock, interrupt;
  logic          operation_busy, operation_complete, operation_error, transmission;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [0:0]    s_axis_tid, s_axis_tdest, s_axis_tuser;
  logic [CH*DW-1:0] m_axis_tdata;
  logic [CH*KW-1:0] m_axis_tkeep;
  logic [CH-1:0] m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [CH-1:0] m_axis_tid, m_axis_tdest, m_axis_tuser;

  axis_packet_splitter #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .operation_start(operation_start),
    .use_channels(use_channels), .split_lengths(split_lengths),
    .lock(lock), .interrupt(interrupt),
    .operation_busy(operation_busy), .operation_complete(operation_complete),
    .operation_error(operation_error), .transmission(transmission),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tid(s_axis_tid),
    .s_axis_tdest(s_axis_tdest), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
    .m_axis_tdest(m_axis_tdest), .m_axis_tuser(m_axis_tuser)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor state: entries are {tlast, tkeep, tdata}
  logic [18:0] got_q [CH][$];
  logic [18:0] exp_q [CH][$];
  int n_in, n_drain, n_err, n_cmp, n_trans, n_lock_viol;
  bit busy_seen;
  int rdy_mode;

  logic [DW-1:0] data_w [64];
  logic [KW-1:0] keep_w [64];

  always @(negedge clk) begin
    for (int c = 0; c < CH; c++)
      if (m_axis_tvalid[c] && m_axis_tready[c])
        got_q[c].push_back({m_axis_tlast[c], m_axis_tkeep[c*KW +: KW], m_axis_tdata[c*DW +: DW]});
    if (s_axis_tvalid && s_axis_tready) begin
      n_in++;
      if (m_axis_tvalid == '0) n_drain++;
    end
    if (operation_error)    n_err++;
    if (operation_complete) n_cmp++;
    if (operation_busy)     busy_seen = 1'b1;
    if (transmission)       n_trans++;
    if (lock && ((s_axis_tvalid && s_axis_tready) || (m_axis_tvalid != '0))) n_lock_viol++;
  end

  // Output back-pressure patterns: all ready, ch0 toggling, or random
  initial begin
    m_axis_tready = '1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       m_axis_tready = {2'b11, ~m_axis_tready[0]};
        2:       m_axis_tready = CH'($urandom_range(0, 7)) | CH'($urandom_range(0, 7));
        default: m_axis_tready = '1;
      endcase
    end
  end

  task automatic clear_mon();
    for (int c = 0; c < CH; c++) begin
      got_q[c].delete();
      exp_q[c].delete();
    end
    n_in = 0; n_drain = 0; n_err = 0; n_cmp = 0; n_trans = 0; n_lock_viol = 0;
    busy_seen = 1'b0;
  endtask

  task automatic send_words(input int n, input int lock_at);
    int  cyc;
    bit  got;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tdata  = data_w[i];
      s_axis_tkeep  = keep_w[i];
      s_axis_tlast  = (i == n - 1);
      s_axis_tvalid = 1'b1;
      if (i == lock_at) begin
        lock = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        lock = 1'b0;
      end
      got = 1'b0;
      cyc = 0;
      while (!got && cyc < 200) begin
        @(negedge clk);
        got = s_axis_tready;
        @(posedge clk); #1;
        cyc++;
      end
      if (!got) begin
        check_val($sformatf("hs_timeout_w%0d", i), 64'd0, 64'd1);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic start_op(input logic [CH-1:0] mask, input int l0, input int l1, input int l2);
    use_channels  = mask;
    split_lengths = {LW'(l2), LW'(l1), LW'(l0)};
    operation_start = 1'b1;
    @(posedge clk); #1;
    operation_start = 1'b0;
  endtask

  // Reference model + comparison for one split operation
  task automatic run_txn(input string name, input logic [CH-1:0] mask, input int l0, input int l1,
                         input int l2, input int n, input int lock_at, input int mode);
    int  lens [CH];
    int  total, idx;
    bit  cfg_ok;
    int  exp_err, exp_cmp, exp_drain;
    lens[0] = l0; lens[1] = l1; lens[2] = l2;
    for (int i = 0; i < n; i++) begin
      data_w[i] = DW'($urandom);
      keep_w[i] = KW'($urandom);
    end
    cfg_ok = (mask != '0);
    total  = 0;
    for (int c = 0; c < CH; c++)
      if (mask[c]) begin
        if (lens[c] == 0) cfg_ok = 1'b0;
        total += lens[c];
      end
    clear_mon();
    if (cfg_ok) begin
      idx = 0;
      for (int c = 0; c < CH; c++)
        if (mask[c])
          for (int k = 0; k < lens[c] && idx < n; k++) begin
            exp_q[c].push_back({(k == lens[c] - 1) || (idx == n - 1), keep_w[idx], data_w[idx]});
            idx++;
          end
      exp_err   = (n != total) ? 1 : 0;
      exp_cmp   = (n == total) ? 1 : 0;
      exp_drain = (n > total) ? n - total : 0;
    end else begin
      exp_err = 1; exp_cmp = 0; exp_drain = 0;
    end
    rdy_mode = mode;
    start_op(mask, l0, l1, l2);
    if (cfg_ok) begin
      send_words(n, lock_at);
    end else begin
      @(negedge clk);
      check_val({name, "_err_next"}, 64'(operation_error), 64'd1);
    end
    repeat (8) @(posedge clk);
    #1;
    rdy_mode = 0;
    for (int c = 0; c < CH; c++) begin
      check_val($sformatf("%s_ch%0d_count", name, c), 64'(got_q[c].size()), 64'(exp_q[c].size()));
      for (int k = 0; k < got_q[c].size() && k < exp_q[c].size(); k++)
        check_val($sformatf("%s_ch%0d_w%0d", name, c, k), 64'(got_q[c][k]), 64'(exp_q[c][k]));
    end
    check_val({name, "_error"},    64'(n_err),     64'(exp_err));
    check_val({name, "_complete"}, 64'(n_cmp),     64'(exp_cmp));
    check_val({name, "_drain"},    64'(n_drain),   64'(exp_drain));
    check_val({name, "_busy"},     64'(busy_seen), 64'(cfg_ok));
    check_val({name, "_inwords"},  64'(n_in),      64'(cfg_ok ? n : 0));
    check_val({name, "_trans"},    64'(n_trans),   64'(n_in));
    check_val({name, "_lock"},     64'(n_lock_viol), 64'd0);
  endtask

  initial begin
    int m, a, b, c, tot, n;
    rst = 1'b1; operation_start = 1'b0; use_channels = '0; split_lengths = '0;
    lock = 1'b0; interrupt = 1'b0; rdy_mode = 0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tid = '0; s_axis_tdest = '0; s_axis_tuser = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_busy",     64'(operation_busy),     64'd0);
    check_val("rst_complete", 64'(operation_complete), 64'd0);
    check_val("rst_error",    64'(operation_error),    64'd0);
    check_val("rst_trans",    64'(transmission),       64'd0);
    check_val("rst_tready",   64'(s_axis_tready),      64'd0);
    check_val("rst_tvalid",   64'(m_axis_tvalid),      64'd0);
    @(posedge clk); #1;

    run_txn("nominal",  3'b101, 4, 0, 2, 6, -1, 0);
    run_txn("toggle",   3'b101, 4, 0, 2, 6, -1, 1);
    run_txn("early",    3'b101, 4, 0, 2, 3, -1, 0);
    run_txn("drain",    3'b101, 4, 0, 2, 8, -1, 0);
    run_txn("nomask",   3'b000, 4, 0, 2, 6, -1, 0);
    run_txn("zerolen",  3'b101, 4, 0, 0, 6, -1, 0);
    run_txn("lock",     3'b101, 4, 0, 2, 6, 2, 0);

    // Interrupt two words into a packet, then a clean split must follow
    clear_mon();
    for (int i = 0; i < 2; i++) begin data_w[i] = DW'($urandom); keep_w[i] = KW'($urandom); end
    start_op(3'b101, 4, 0, 2);
    send_words(2, -1);
    interrupt = 1'b1;
    @(posedge clk); #1;
    interrupt = 1'b0;
    @(negedge clk);
    check_val("intr_busy",   64'(operation_busy), 64'd0);
    check_val("intr_tready", 64'(s_axis_tready),  64'd0);
    @(posedge clk); #1;
    run_txn("post_intr", 3'b101, 4, 0, 2, 6, -1, 0);

    for (int t = 0; t < 12; t++) begin
      m = $urandom_range(0, 7);
      a = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      c = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      tot = (m[0] ? a : 0) + (m[1] ? b : 0) + (m[2] ? c : 0);
      n = tot + $urandom_range(0, 4) - 2;
      if (n < 1) n = 1;
      run_txn($sformatf("rnd%0d", t), CH'(m), a, b, c, n,
              ($urandom_range(0, 3) == 0) ? 1 : -1, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
